serial_alu_ctrl: RTL and testbench
==================================

Name: serial_alu_ctrl

Overview:
Bit-serial multi-bit ALU sequencer that drives the team's 1-bit ALU slice function (add/and/nor/xor on a, b, carry-in) across WIDTH cycles, LSB first.
- Holds the inter-bit carry in a register, shifts operands and the result, and reports completion with a start/busy/done handshake.
- Sits between a register-file/control FSM and the 1-bit slice. The slice function is replicated internally so the block is self-contained.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); also the number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
op_a  input  WIDTH  operand A, latched when start accepted
op_b  input  WIDTH  operand B, latched when start accepted
aluctr  input  2  op select, latched with operands: 00 add, 01 and, 10 nor, 11 xor
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result/cout valid
result  output  WIDTH  operation result; held until next accepted start
cout  output  1  final carry for add; 0 for all other ops

Behaviour:
- Reset: async on rst_n low.
  - State IDLE; busy=0, done=0, result=0, cout=0.
  - Carry register=0, bit counter=0, shift registers=0.
- Slice function per bit:
  - 00: sum and carry of a+b+c.
  - 01: a&b. 10: ~(a|b). 11: a^b.
  - For non-add ops the carry-out is 0.
- States:
  - IDLE: start=1 at an edge latches op_a, op_b, aluctr; carry=0; counter=0; go to RUN.
  - RUN: each edge processes the LSBs of the A/B shift registers with the carry register.
    - The slice output bit shifts into the result register at the MSB side; A/B shift right.
    - Carry register takes the slice carry-out (add only, else 0). Counter increments.
    - When the counter reaches WIDTH-1 at an edge, go to DONE.
  - DONE: done=1 for exactly one cycle; cout = carry register.
    - Next edge: start=1 accepts a new operation (go to RUN, result/cout keep the old values until overwritten); otherwise go to IDLE.
- Latency: start sampled at edge 0; bit i processed at edge i+1.
  - After edge WIDTH the state is DONE and done is high.
  - busy high from edge 0 until edge WIDTH.
- result register: updates only during RUN.
  - Intermediate values are visible but undefined to consumers until done.
  - Held stable in DONE and IDLE.
- start while busy: ignored; latched operands and aluctr are unaffected by input changes during RUN.
- Back-to-back: start held high continuously yields an operation every WIDTH+1 cycles.
- Counter width: clog2(WIDTH) bits; no wrap beyond WIDTH-1.
- Reset asserted mid-RUN: immediate abort.
  - All outputs return to reset values; no done pulse.
  - After release, state is IDLE.
- aluctr illegal values: none; all 4 encodings are defined.

Test Plan:
- Add carry-out: WIDTH=8, op_a=8'hFF, op_b=8'h01, aluctr=00, start 1 cycle -> busy 8 cycles; done pulse after edge 8; result=8'h00, cout=1.
- Add no carry: op_a=8'h3C, op_b=8'h15, aluctr=00 -> result=8'h51, cout=0.
- Logic ops:
  - and 8'hA5, 8'h3C -> 8'h24.
  - nor 8'h0F, 8'h30 -> 8'hC0.
  - xor 8'hA5, 8'hFF -> 8'h5A.
  - cout=0 for all three.
- Start while busy: start add 8'h01+8'h01; re-pulse start with op_a=8'hFF, aluctr=11 at cycle 3 -> ignored; result=8'h02; exactly one done pulse.
- Back-to-back:
  - start held high with 8'h10+8'h20, then 8'h0F&8'hF5 presented at the DONE cycle -> done pulses 9 cycles apart.
  - Results 8'h30 then 8'h05; busy low only during the DONE cycle.
- Reset mid-op: assert rst_n=0 at RUN cycle 4 for 1 cycle -> busy, done, result, cout = 0 immediately; stays IDLE; no done until a new start.

Source files
------------

// File: rtl/serial_alu_ctrl_if.sv
// serial_alu_ctrl_if: request/response bundle for the bit-serial ALU sequencer.
//   start  : operation request (master -> slave)
//   op_a   : operand A        (master -> slave)
//   op_b   : operand B        (master -> slave)
//   aluctr : op select 00 add, 01 and, 10 nor, 11 xor (master -> slave)
//   busy   : high while the operation runs      (slave -> master)
//   done   : one-cycle completion pulse         (slave -> master)
//   result : operation result                   (slave -> master)
//   cout   : final add carry, 0 for logic ops   (slave -> master)
interface serial_alu_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       aluctr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output start, op_a, op_b, aluctr,
    input  busy, done, result, cout
  );

  modport slave (
    input  start, op_a, op_b, aluctr,
    output busy, done, result, cout
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer. Runs a 1-bit ALU slice over
// WIDTH cycles, LSB first, keeping the inter-bit carry in a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_alu_ctrl_if (start/op_a/op_b/aluctr in,
//           busy/done/result/cout out)
module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_alu_ctrl_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic             slice_out;
  logic             slice_cout;

  // 1-bit ALU slice on the operand LSBs and the carry register
  always_comb begin
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    unique case (op_q)
      2'b00: begin
        slice_out  = a_q[0] ^ b_q[0] ^ carry_q;
        slice_cout = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      end
      2'b01: slice_out = a_q[0] & b_q[0];
      2'b10: slice_out = ~(a_q[0] | b_q[0]);
      2'b11: slice_out = a_q[0] ^ b_q[0];
      default: ;
    endcase
  end

  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          op_d    = bus.aluctr;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d = {slice_out, result_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = slice_cout;
        if (cnt_q == LAST) begin
          // cout is captured on the final bit so it is valid in the DONE cycle
          // and holds through any following RUN until the next completion
          cout_d  = slice_cout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy   = (state_q == S_RUN);
    bus.done   = (state_q == S_DONE);
    bus.result = result_q;
    bus.cout   = cout_q;
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed bench for serial_alu_ctrl (WIDTH=8).
module tb_serial_alu_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_alu_ctrl_if #(.WIDTH(W)) bus ();

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step edges until done is seen; reports edge count (0 on timeout)
  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] ctr, input logic [7:0] er, input logic ec);
    int n;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.aluctr = ctr;
    tick();
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.aluctr = 2'b00;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(tag, n);
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    tick();
    check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, 32'(bus.result), 32'(er));
  endtask

  initial begin
    int n;
    int pulses;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.aluctr = 2'b00;
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("add_carry", 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);
    run_op("add_nocarry", 8'h3C, 8'h15, 2'b00, 8'h51, 1'b0);
    run_op("and", 8'hA5, 8'h3C, 2'b01, 8'h24, 1'b0);
    run_op("nor", 8'h0F, 8'h30, 2'b10, 8'hC0, 1'b0);
    run_op("xor", 8'hA5, 8'hFF, 2'b11, 8'h5A, 1'b0);

    // start while busy is ignored
    bus.start = 1'b1; bus.op_a = 8'h01; bus.op_b = 8'h01; bus.aluctr = 2'b00;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) begin
        bus.start = 1'b1; bus.op_a = 8'hFF; bus.aluctr = 2'b11;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done === 1'b1) begin
        pulses++;
        check("busy_ign_result", 32'(bus.result), 32'h02);
        check("busy_ign_lat", 32'(i), 32'd8);
      end
    end
    check("busy_ign_pulses", 32'(pulses), 32'd1);
    bus.op_a = '0; bus.op_b = '0; bus.aluctr = 2'b00;

    // back-to-back with start held high
    bus.start = 1'b1; bus.op_a = 8'h10; bus.op_b = 8'h20; bus.aluctr = 2'b00;
    tick();
    wait_done("b2b_first", n);
    check("b2b_r1", 32'(bus.result), 32'h30);
    check("b2b_busy_done", 32'(bus.busy), 32'd0);
    bus.op_a = 8'h0F; bus.op_b = 8'hF5; bus.aluctr = 2'b01;
    tick();
    check("b2b_busy_run", 32'(bus.busy), 32'd1);
    check("b2b_r1_held", 32'(bus.cout), 32'd0);
    wait_done("b2b_second", n);
    check("b2b_spacing", 32'(n + 1), 32'd9);
    check("b2b_r2", 32'(bus.result), 32'h05);
    bus.start = 1'b0;
    tick();
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // carry-out of 1 held into the next op, then reset mid-run
    run_op("add_carry2", 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);
    bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h0F; bus.aluctr = 2'b00;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    check("mid_result_partial", 32'(bus.result[7:4]), 32'h9);
    check("mid_cout_held", 32'(bus.cout), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    check("abort_stays_idle", 32'(pulses), 32'd0);
    run_op("post_abort", 8'h3C, 8'h15, 2'b00, 8'h51, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
